io_lcd_driver: RTL and testbench
================================

# io_lcd_driver

Peripheral-side consumer of the CPU's LCD output register (`o_io_lcd`).
- Decodes each software-issued request word.
- Generates HD44780-compatible bus cycles (RS/RW/EN/DB[7:0]) with programmable setup, pulse, hold and execution timing.
- Returns read data and a busy flag so firmware can pace its writes.
- Sits on the board top level between the single-cycle core's LCD register and the LCD header pins, on the core clock.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles RS/RW/DB held stable before EN rises.
- `PULSE_CYC`, 12: cycles EN held high.
- `HOLD_CYC`, 2: cycles RS/RW/DB held after EN falls.
- `EXEC_CYC`, 1000: post-write wait for normal instructions/data.
- `LONG_EXEC_CYC`, 41000: post-write wait for clear/home commands.

Ports:
- `i_clk`  in  1  core clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_lcd_reg`  in  32  request word:
  - [7:0] data
  - [8] RS
  - [9] RW
  - [10] REQ toggle
  - [31] ON
  - other bits ignored
- `i_lcd_data`  in  8  DB pins, input path.
- `o_lcd_data`  out  8  DB pins, output path.
- `o_lcd_data_oe`  out  1  DB output enable.
- `o_lcd_rs`  out  1  register select.
- `o_lcd_rw`  out  1  read/write.
- `o_lcd_en`  out  1  enable strobe.
- `o_lcd_on`  out  1  panel power/backlight.
- `o_busy`  out  1  transaction in progress.
- `o_rd_data`  out  8  last read byte.

## Operation
- **Request detection:** `last_req` holds the last accepted value of `i_lcd_reg[10]`. In IDLE, a request starts when `i_lcd_reg[10] != last_req`. On start, the block latches data/RS/RW and updates `last_req`.
- **First cycle after reset:** `last_req` loads `i_lcd_reg[10]` without starting a transaction (arming cycle). A stale toggle never fires after reset.
- **States:**
  - IDLE
  - SETUP: `SETUP_CYC` cycles
  - PULSE: `PULSE_CYC` cycles, EN=1
  - HOLD: `HOLD_CYC` cycles
  - EXEC: write only
  - then back to IDLE
- A single down-counter, reloaded on each state entry, times all states.
- **Writes (RW=0):**
  - DB output is enabled from SETUP through HOLD.
  - EXEC length is `LONG_EXEC_CYC` when RS=0 and data ∈ {0x01, 0x02, 0x03}, else `EXEC_CYC`.
- **Reads (RW=1):**
  - `o_lcd_data_oe`=0 for the whole transaction.
  - `i_lcd_data` is sampled into `o_rd_data` on the last PULSE cycle.
  - After HOLD the FSM returns to IDLE; no EXEC.
- **Toggles while busy:** Compared only on return to IDLE.
  - An odd number of toggles yields exactly one new transaction.
  - An even number yields none.
  - Firmware must poll `o_busy`.
- **`o_lcd_on`:** Registered copy of `i_lcd_reg[31]`, independent of FSM state.
- **Outputs in IDLE:** EN=0, oe=0; RS/RW/DB keep their last driven values.

## Timing
- **Reset values:**
  - All outputs 0.
  - `last_req` 0; FSM in IDLE; arming pending.
- **Reset mid-transaction:** EN, busy and oe drop immediately (async). The transaction is abandoned; there is no resumption.
- **Start latency:** Toggle visible in cycle N → SETUP, busy=1 and RS/RW/DB driven from N+1.
- **Strobe and completion:**
  - EN=1 over cycles N+1+SETUP_CYC … N+SETUP_CYC+PULSE_CYC.
  - busy=0 first at N+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+exec.
- **Back-to-back:** A new request can be accepted in the same cycle the FSM re-enters IDLE.
- **Counter width:** Sized for `LONG_EXEC_CYC`. Zero-valued parameters are treated as 1 cycle.

## Configuration
- **`LCD_BUSY_POLL_EN` defined:**
  - EXEC is replaced by polling.
  - The block issues internal reads (RS=0, RW=1) with the same SETUP/PULSE/HOLD timing until sampled DB7=0.
  - `o_rd_data` is not updated by poll reads.
  - `EXEC_CYC`/`LONG_EXEC_CYC` are unused.
- **Undefined:** Fixed-count EXEC wait as described above.

## Test plan
All scenarios use default parameters and no macro.
- **Write 0x38:** RS=0, toggle 0→1 at cycle N → EN high cycles N+3..N+14, DB=0x38, oe=1, busy high for 1016 cycles.
- **Clear 0x01:** → busy high for 41016 cycles.
- **Read:** RW=1, RS=1, `i_lcd_data`=0x5A → oe=0 throughout, `o_rd_data`=0x5A after PULSE, busy high 16 cycles.
- **Toggles during write busy:**
  - One toggle during a write's busy period → second transaction's SETUP begins the cycle busy would drop (busy stays 1).
  - Two toggles → busy drops, no second transaction.
- **Reset during PULSE:** Assert `i_reset` mid-PULSE with bit10=1 held → EN/busy/oe 0 asynchronously. After release, no transaction starts until bit10 toggles.
- **ON passthrough:** Toggle bit31 with no REQ change → `o_lcd_on` follows one cycle later, busy stays 0.

Source files
------------

// File: rtl/io_lcd_driver.sv
// io_lcd_driver: turns the core's LCD request register into HD44780-style
// bus cycles (RS/RW/EN/DB) with programmable setup, pulse, hold and
// execution timing, and reports busy status and read data to firmware.
// Optional build macro LCD_BUSY_POLL_EN: after a write, poll the panel's
// busy flag (DB7) with internal reads instead of waiting a fixed EXEC count.
module io_lcd_driver #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 1000,
  parameter int LONG_EXEC_CYC = 41000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_reg,
  input  logic [7:0]  i_lcd_data,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic [7:0]  o_rd_data
);

  // Zero-length phases are stretched to one cycle.
  localparam int SETUP_L = (SETUP_CYC     < 1) ? 1 : SETUP_CYC;
  localparam int PULSE_L = (PULSE_CYC     < 1) ? 1 : PULSE_CYC;
  localparam int HOLD_L  = (HOLD_CYC      < 1) ? 1 : HOLD_CYC;
  localparam int EXEC_L  = (EXEC_CYC      < 1) ? 1 : EXEC_CYC;
  localparam int LONG_L  = (LONG_EXEC_CYC < 1) ? 1 : LONG_EXEC_CYC;

  localparam int MAX_A   = (SETUP_L > PULSE_L) ? SETUP_L : PULSE_L;
  localparam int MAX_B   = (HOLD_L  > EXEC_L)  ? HOLD_L  : EXEC_L;
  localparam int MAX_C   = (MAX_A   > MAX_B)   ? MAX_A   : MAX_B;
  localparam int MAX_L   = (MAX_C   > LONG_L)  ? MAX_C   : LONG_L;
  // Counter holds values 0 .. MAX_L-1.
  localparam int CNT_W   = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_L - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_L - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_L  - 1);
`ifndef LCD_BUSY_POLL_EN
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_L  - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_L  - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_last_req;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_rw;
  logic [7:0]       r_rd_data;
  logic             r_on;

  logic             w_req_pend;
  logic             w_cnt_zero;
  logic             w_finish;
  logic             w_start;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_unused;

`ifdef LCD_BUSY_POLL_EN
  logic             r_poll;
  logic             r_poll_busy;
  logic             w_poll_start;
`else
  logic             w_is_long;
`endif

  // Request word bits that carry no meaning for this block.
  assign w_unused   = ^i_lcd_reg[30:11];

  assign w_req_pend = r_armed && (i_lcd_reg[10] != r_last_req);
  assign w_cnt_zero = (r_cnt == '0);

`ifndef LCD_BUSY_POLL_EN
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign w_is_long  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each phase ends when the shared counter reaches zero;
  // a finished transaction chains straight into a pending request.
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
`ifdef LCD_BUSY_POLL_EN
    w_poll_start = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_finish = 1'b1;
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PULSE;
          w_load      = 1'b1;
          w_load_val  = PULSE_LD;
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_load      = 1'b1;
          w_load_val  = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
`ifdef LCD_BUSY_POLL_EN
          // Writes and still-busy polls issue another status read.
          if (!r_rw || (r_poll && r_poll_busy)) begin
            w_poll_start = 1'b1;
            w_state_nxt  = S_SETUP;
            w_load       = 1'b1;
            w_load_val   = SETUP_LD;
          end else begin
            w_finish = 1'b1;
          end
`else
          if (!r_rw) begin
            w_state_nxt = S_EXEC;
            w_load      = 1'b1;
            w_load_val  = w_is_long ? LONG_LD : EXEC_LD;
          end else begin
            w_finish = 1'b1;
          end
`endif
        end
      end
      S_EXEC: begin
        if (w_cnt_zero) begin
          w_finish = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_finish) begin
      if (w_req_pend) begin
        w_start     = 1'b1;
        w_state_nxt = S_SETUP;
        w_load      = 1'b1;
        w_load_val  = SETUP_LD;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Shared phase down-counter, reloaded on every state entry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= w_load_val;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Request toggle tracking; the first cycle after reset only arms.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_armed    <= 1'b0;
      r_last_req <= 1'b0;
    end else if (!r_armed) begin
      r_armed    <= 1'b1;
      r_last_req <= i_lcd_reg[10];
    end else if (w_start) begin
      r_last_req <= i_lcd_reg[10];
    end
  end

  // Bus fields latched at transaction start; they persist through IDLE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data <= 8'h00;
      r_rs   <= 1'b0;
      r_rw   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      r_poll <= 1'b0;
`endif
    end else if (w_start) begin
      r_data <= i_lcd_reg[7:0];
      r_rs   <= i_lcd_reg[8];
      r_rw   <= i_lcd_reg[9];
`ifdef LCD_BUSY_POLL_EN
      r_poll <= 1'b0;
    end else if (w_poll_start) begin
      r_rs   <= 1'b0;
      r_rw   <= 1'b1;
      r_poll <= 1'b1;
`endif
    end
  end

  // Capture DB on the last cycle of the enable pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data   <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
      r_poll_busy <= 1'b0;
`endif
    end else if ((r_state == S_PULSE) && w_cnt_zero) begin
`ifdef LCD_BUSY_POLL_EN
      if (r_poll) begin
        r_poll_busy <= i_lcd_data[7];
      end else if (r_rw) begin
        r_rd_data <= i_lcd_data;
      end
`else
      if (r_rw) begin
        r_rd_data <= i_lcd_data;
      end
`endif
    end
  end

  // Panel power follows the request word with one cycle of delay.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_on <= 1'b0;
    end else begin
      r_on <= i_lcd_reg[31];
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_lcd_en      = (r_state == S_PULSE);
  assign o_lcd_data_oe = !r_rw && ((r_state == S_SETUP) || (r_state == S_PULSE) ||
                                   (r_state == S_HOLD));
  assign o_lcd_data    = r_data;
  assign o_lcd_rs      = r_rs;
  assign o_lcd_rw      = r_rw;
  assign o_lcd_on      = r_on;
  assign o_rd_data     = r_rd_data;

endmodule

// File: tb/tb_io_lcd_driver.sv
// Directed testbench for io_lcd_driver with default parameters.
module tb_io_lcd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lcd_reg;
  logic [7:0]  lcd_din;
  logic [7:0]  lcd_dout;
  logic        lcd_oe;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic        busy;
  logic [7:0]  rd_data;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic tog    = 1'b0;

  int         blen;
  int         en_first;
  int         en_last;
  int         oe_cnt;
  logic [7:0] db_en;
  logic       rs_en;
  logic       rw_en;
  int         busy_seen;

  always #5 clk = ~clk;

  io_lcd_driver dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_lcd_reg     (lcd_reg),
    .i_lcd_data    (lcd_din),
    .o_lcd_data    (lcd_dout),
    .o_lcd_data_oe (lcd_oe),
    .o_lcd_rs      (lcd_rs),
    .o_lcd_rw      (lcd_rw),
    .o_lcd_en      (lcd_en),
    .o_lcd_on      (lcd_on),
    .o_busy        (busy),
    .o_rd_data     (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] d, input logic rs, input logic rw,
                                     input logic tg, input logic on);
    return {on, 20'd0, tg, rw, rs, d};
  endfunction

  // Issue one request (toggle visible in the current cycle N) and follow
  // the bus until busy drops. Cycle k is the k-th cycle after N.
  task automatic run_txn(input string tag, input logic [7:0] d, input logic rs,
                         input logic rw, input int ntog, input int maxcyc);
    blen = 0; en_first = -1; en_last = -1; oe_cnt = 0;
    db_en = 8'h00; rs_en = 1'b0; rw_en = 1'b0;
    tog = ~tog;
    lcd_reg = mk(d, rs, rw, tog, 1'b0);
    for (int k = 1; k <= maxcyc; k++) begin
      step();
      if (!busy) break;
      blen++;
      if (lcd_en) begin
        if (en_first < 0) begin
          en_first = k;
          db_en    = lcd_dout;
          rs_en    = lcd_rs;
          rw_en    = lcd_rw;
        end
        en_last = k;
      end
      if (lcd_oe) oe_cnt++;
      if ((k == 20 && ntog >= 1) || (k == 30 && ntog >= 2)) begin
        tog = ~tog;
        lcd_reg[10] = tog;
      end
    end
    check({tag, "_done"}, busy, 0);
  endtask

  initial begin
    rst     = 1'b1;
    lcd_reg = 32'h0;
    lcd_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_en", lcd_en, 0);
    check("rst_oe", lcd_oe, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_db", lcd_dout, 0);
    check("rst_rd", rd_data, 0);
    check("rst_on", lcd_on, 0);
    rst = 1'b0;
    step();
    step();
    check("idle_busy", busy, 0);

    // Function set write 0x38
    run_txn("wr38", 8'h38, 1'b0, 1'b0, 0, 1100);
    check("wr38_busy_len", blen, 1016);
    check("wr38_en_first", en_first, 3);
    check("wr38_en_last", en_last, 14);
    check("wr38_oe_cnt", oe_cnt, 16);
    check("wr38_db", db_en, 8'h38);
    check("wr38_rs", rs_en, 0);
    check("wr38_rw", rw_en, 0);
    check("wr38_idle_en", lcd_en, 0);
    check("wr38_idle_oe", lcd_oe, 0);
    check("wr38_idle_db", lcd_dout, 8'h38);
    check("wr38_rd_untouched", rd_data, 0);

    // Clear display uses the long execution wait
    run_txn("clr", 8'h01, 1'b0, 1'b0, 0, 42000);
    check("clr_busy_len", blen, 41016);
    check("clr_en_first", en_first, 3);

    // Data read
    lcd_din = 8'h5A;
    run_txn("rd", 8'h00, 1'b1, 1'b1, 0, 100);
    check("rd_busy_len", blen, 16);
    check("rd_oe_cnt", oe_cnt, 0);
    check("rd_en_first", en_first, 3);
    check("rd_en_last", en_last, 14);
    check("rd_rs", rs_en, 1);
    check("rd_rw", rw_en, 1);
    check("rd_data", rd_data, 8'h5A);
    lcd_din = 8'hA5;

    // One toggle while busy: second write chains without a busy gap
    run_txn("tog1", 8'h38, 1'b0, 1'b0, 1, 2200);
    check("tog1_busy_len", blen, 2032);
    check("tog1_oe_cnt", oe_cnt, 32);
    check("tog1_rd_kept", rd_data, 8'h5A);

    // Two toggles while busy: no second transaction
    run_txn("tog2", 8'h06, 1'b0, 1'b0, 2, 2200);
    check("tog2_busy_len", blen, 1016);
    busy_seen = 0;
    repeat (5) begin
      step();
      if (busy) busy_seen++;
    end
    check("tog2_no_restart", busy_seen, 0);

    // Reset in the middle of the enable pulse, bit10 held at 1
    tog = ~tog;
    lcd_reg = mk(8'h38, 1'b0, 1'b0, tog, 1'b0);
    repeat (5) step();
    check("rstp_pre_en", lcd_en, 1);
    check("rstp_pre_req", lcd_reg[10], 1);
    rst = 1'b1;
    #1;
    check("rstp_en", lcd_en, 0);
    check("rstp_busy", busy, 0);
    check("rstp_oe", lcd_oe, 0);
    check("rstp_db", lcd_dout, 0);
    step();
    step();
    rst = 1'b0;
    busy_seen = 0;
    repeat (10) begin
      step();
      if (busy || lcd_en) busy_seen++;
    end
    check("rstp_no_stale", busy_seen, 0);
    run_txn("post_rst", 8'h0C, 1'b0, 1'b0, 0, 1100);
    check("post_rst_busy_len", blen, 1016);
    check("post_rst_db", db_en, 8'h0C);

    // ON passthrough with no request change
    lcd_reg[31] = 1'b1;
    #1;
    check("on_same_cycle", lcd_on, 0);
    step();
    check("on_set", lcd_on, 1);
    check("on_busy", busy, 0);
    lcd_reg[31] = 1'b0;
    step();
    check("on_clear", lcd_on, 0);
    check("on_busy2", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
